// File: rtl/queue_pkg.sv
// ============================================================================
// queue_pkg : shared types, defaults and sizing helper for the parametrised queue.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package queue_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_e;

    // One extra bit beyond the index width lets a pointer or count reach DEPTH.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/queue_dpram.sv
// ============================================================================
// queue_dpram : one write port, one synchronous read port, storage not reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module queue_dpram
    import queue_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // rdata_q holds between reads so the consumer sees a stable word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/param_queue_fifo.sv
// ============================================================================
// param_queue_fifo : synchronous FIFO with occupancy count and threshold flags.
// Optional macro QUEUE_ERR_EN adds err_clr / overflow / underflow.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module param_queue_fifo
    import queue_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          din,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      dout_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic [ptr_w(DEPTH)-1:0]   count
`ifdef QUEUE_ERR_EN
    ,
    input  logic                      err_clr,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = ptr_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q;
    logic             has_rd_q;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] ram_rdata;
    q_state_e         state;
    logic             w_unused_ptr_msb;

    always_comb begin
        state = Q_PARTIAL;
        if (count_q == '0) begin
            state = Q_EMPTY;
        end else if (count_q == DEPTH_C) begin
            state = Q_FULL;
        end
    end

    assign empty        = (state == Q_EMPTY);
    assign full         = (state == Q_FULL);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            has_rd_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= rd_acc;
            if (rd_acc) begin
                has_rd_q <= 1'b1;
            end
        end
    end

    queue_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (din),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // The RAM output is unreset; mask it until the first accepted read after reset.
    assign dout       = has_rd_q ? ram_rdata : '0;
    assign dout_valid = valid_q;

    // Occupancy lives in count_q, so the wrap bits only keep the pointers full-width.
    assign w_unused_ptr_msb = wr_ptr_q[CW-1] ^ rd_ptr_q[CW-1];

`ifdef QUEUE_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

`default_nettype wire
